// File: rtl/demux2way_8bit_buffered_pkg.sv
// Shared widths and types for the buffered 2-way byte demultiplexer.
package demux2way_8bit_buffered_pkg;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNTW  = $clog2(DEPTH) + 1;

    typedef logic [WIDTH-1:0] byte_t;
    typedef logic [CNTW-1:0]  count_t;
endpackage

// File: rtl/demux2way_8bit_buffered_if.sv
// Producer-side and two consumer-side handshakes of the demux, bundled.
interface demux2way_8bit_buffered_if;
    import demux2way_8bit_buffered_pkg::*;

    logic   in_valid;
    logic   in_address;
    byte_t  in_data;
    logic   in_ready;
    logic   out0_valid;
    byte_t  out0_data;
    logic   out0_ready;
    count_t out0_count;
    logic   out1_valid;
    byte_t  out1_data;
    logic   out1_ready;
    count_t out1_count;

    // master: the producer and both consumers; slave: the demux itself
    modport master (
        output in_valid, in_address, in_data, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out0_count, out1_valid, out1_data, out1_count
    );
    modport slave (
        input  in_valid, in_address, in_data, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out0_count, out1_valid, out1_data, out1_count
    );
endinterface

// File: rtl/demux2way_8bit_buffered_byte_fifo.sv
// Per-channel byte FIFO: registered storage, combinational head read, occupancy count.
module demux2way_8bit_buffered_byte_fifo
    import demux2way_8bit_buffered_pkg::*;
#(
    parameter int unsigned  Width = WIDTH,
    parameter int unsigned  Depth = DEPTH,
    localparam int unsigned PtrW  = $clog2(Depth),
    localparam int unsigned CntW  = PtrW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [CntW-1:0]  count,
    output logic [Width-1:0] head
);
    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CntW'(Depth));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push & ~full & ~reset;
    assign do_pop  = pop & ~empty & ~reset;

    // Depth is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (do_push && !do_pop) begin
                count_q <= count_q + CntW'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/demux2way_8bit_buffered.sv
// Steers each input byte to one of two buffered output channels by its address bit.
module demux2way_8bit_buffered
    import demux2way_8bit_buffered_pkg::*;
(
    input logic                       clk,
    input logic                       reset,
    demux2way_8bit_buffered_if.slave  bus
);
    logic full0, full1, empty0, empty1;
    logic in_ready, push0, push1;

    // Full channel refuses input even if its consumer pops this cycle
    assign in_ready     = bus.in_address ? ~full1 : ~full0;
    assign bus.in_ready = in_ready;
    assign push0        = bus.in_valid & in_ready & ~bus.in_address;
    assign push1        = bus.in_valid & in_ready & bus.in_address;

    demux2way_8bit_buffered_byte_fifo #(
        .Width (WIDTH),
        .Depth (DEPTH)
    ) u_fifo0 (
        .clk   (clk),
        .reset (reset),
        .push  (push0),
        .pop   (bus.out0_ready),
        .wdata (bus.in_data),
        .full  (full0),
        .empty (empty0),
        .count (bus.out0_count),
        .head  (bus.out0_data)
    );

    demux2way_8bit_buffered_byte_fifo #(
        .Width (WIDTH),
        .Depth (DEPTH)
    ) u_fifo1 (
        .clk   (clk),
        .reset (reset),
        .push  (push1),
        .pop   (bus.out1_ready),
        .wdata (bus.in_data),
        .full  (full1),
        .empty (empty1),
        .count (bus.out1_count),
        .head  (bus.out1_data)
    );

    assign bus.out0_valid = ~empty0;
    assign bus.out1_valid = ~empty1;
endmodule

// File: tb/tb_demux2way_8bit_buffered.sv
// Scoreboard bench: occupancy model plus per-channel expected-byte queues, checked on negedge.
module tb_demux2way_8bit_buffered;
    import demux2way_8bit_buffered_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    demux2way_8bit_buffered_if bus ();

    demux2way_8bit_buffered dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    byte_t sb0[$];
    byte_t sb1[$];
    int    cnt0 = 0;
    int    cnt1 = 0;
    bit    last_acc = 1'b0;
    bit    acc, pop0, pop1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each channel is a bounded queue of at most DEPTH bytes.
    always @(posedge clk) begin
        if (reset) begin
            sb0.delete();
            sb1.delete();
            cnt0     = 0;
            cnt1     = 0;
            last_acc = 1'b0;
        end else begin
            acc  = bus.in_valid && ((bus.in_address ? cnt1 : cnt0) < int'(DEPTH));
            pop0 = bus.out0_ready && (cnt0 > 0);
            pop1 = bus.out1_ready && (cnt1 > 0);
            if (acc && !bus.in_address) sb0.push_back(bus.in_data);
            if (acc && bus.in_address)  sb1.push_back(bus.in_data);
            cnt0 = cnt0 + int'(acc && !bus.in_address) - int'(pop0);
            cnt1 = cnt1 + int'(acc && bus.in_address) - int'(pop1);
            last_acc = acc;
        end
    end

    // Monitor: compare flags/counts every cycle and popped bytes against the scoreboard.
    always @(negedge clk) begin
        chk("in_ready", 32'(bus.in_ready),
            32'(((bus.in_address ? cnt1 : cnt0) < int'(DEPTH)) ? 1 : 0));
        chk("out0_valid", 32'(bus.out0_valid), 32'((cnt0 > 0) ? 1 : 0));
        chk("out1_valid", 32'(bus.out1_valid), 32'((cnt1 > 0) ? 1 : 0));
        chk("out0_count", 32'(bus.out0_count), 32'(cnt0));
        chk("out1_count", 32'(bus.out1_count), 32'(cnt1));
        if (!reset && cnt0 > 0 && bus.out0_ready && sb0.size() > 0) begin
            chk("out0_data", 32'(bus.out0_data), 32'(sb0.pop_front()));
        end
        if (!reset && cnt1 > 0 && bus.out1_ready && sb1.size() > 0) begin
            chk("out1_data", 32'(bus.out1_data), 32'(sb1.pop_front()));
        end
    end

    task automatic step(input bit v, input bit a, input byte_t d, input bit r0, input bit r1,
                        input bit rst);
        bus.in_valid   = v;
        bus.in_address = a;
        bus.in_data    = d;
        bus.out0_ready = r0;
        bus.out1_ready = r1;
        reset          = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic push_hold(input bit a, input byte_t d, input bit r0, input bit r1);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, a, d, r0, r1, 1'b0);
            if (last_acc) return;
        end
        chk("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input bit r0, input bit r1, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, r0, r1, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_address = 1'b0; bus.in_data = '0;
        bus.out0_ready = 1'b0; bus.out1_ready = 1'b0; reset = 1'b1;

        // Reset, then idle
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        idle(1'b0, 1'b0, 2);

        // One byte to each channel
        push_hold(1'b0, 8'hA5, 1'b0, 1'b0);
        chk("t2_out0_data", 32'(bus.out0_data), 32'h A5);
        push_hold(1'b1, 8'h3C, 1'b0, 1'b0);
        chk("t2_out1_data", 32'(bus.out1_data), 32'h3C);
        idle(1'b0, 1'b0, 1);
        idle(1'b1, 1'b1, 2);

        // Fill channel 0, back-pressure, then accept the fifth byte after a pop
        for (int i = 1; i <= 4; i++) push_hold(1'b0, byte_t'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        push_hold(1'b0, 8'h05, 1'b1, 1'b0);
        idle(1'b1, 1'b0, 5);

        // Simultaneous push and pop on a two-entry channel
        push_hold(1'b0, 8'h21, 1'b0, 1'b0);
        push_hold(1'b0, 8'h22, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h23, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 1'b0, 3);

        // Pointer wrap on channel 1 with interleaved pops
        for (int i = 0; i < 6; i++) push_hold(1'b1, byte_t'(8'h10 + i), 1'b0, i[0]);
        idle(1'b0, 1'b1, 6);

        // Reset mid-stream discards buffered bytes and the byte offered during reset
        for (int i = 0; i < 3; i++) push_hold(1'b0, byte_t'(8'h31 + i), 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0, 1'b1);
        idle(1'b1, 1'b0, 2);
        push_hold(1'b0, 8'h44, 1'b0, 1'b0);
        idle(1'b1, 1'b0, 2);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 4) != 0, 1'($urandom % 2), byte_t'($urandom),
                 ($urandom % 3) != 0, ($urandom % 3) == 0, ($urandom % 150) == 0);
        end

        idle(1'b1, 1'b1, 12);
        chk("drain_sb0", 32'(sb0.size()), 32'd0);
        chk("drain_sb1", 32'(sb1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
